mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
Multi-cycle main control FSM for the MIPS datapath. It sits directly upstream of the ALU control decoder and drives its 3-bit ALUOP. It also sequences PC, IR, register-file and memory enables across fetch, decode, execute, memory and writeback states. Memory accesses stall on a ready handshake.

Parameters:
OPW, 6, opcode width (fixed by ISA; present for lint/consistency only)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
Opcode  in  6  IR[31:26]
mem_ready  in  1  memory completes access this cycle
ALUOP  out  3  to ALU control: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 lui, 111 R-type (use Funct)
ALUSrcA  out  1  0=PC, 1=reg A
ALUSrcB  out  2  00=reg B, 01=const 4, 10=ext imm, 11=sext imm<<2
ZeroExt  out  1  1=zero-extend imm (andi/ori/xori)
IorD  out  1  0=PC address, 1=ALUOut address
MemRead / MemWrite / IRWrite / PCWrite  out  1 each  enables
Branch / BranchNE  out  1 each  conditional PC write on Zero / !Zero
PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
RegWrite / RegDst / MemtoReg  out  1 each  register file controls
illegal_op  out  1  one-cycle pulse on undefined opcode
state_dbg  out  4  current state encoding

Behaviour:
- Moore FSM. Outputs decode combinationally from the state register, except the mem_ready-qualified enables listed below.
- States and encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
- Reset: rst=1 at a clk edge sets state=FETCH. While rst=1, every enable output (MemRead, MemWrite, IRWrite, PCWrite, Branch, BranchNE, RegWrite) is forced 0 and illegal_op=0. Reset mid-instruction abandons it; no partial writes occur after the reset edge.
- Default value of every output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=000, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOP=000 (branch target into ALUOut).
  - Next state by Opcode: 35/43 -> MEM_ADDR; 0 -> R_EXEC; 4/5 -> BRANCH; 2 -> JUMP; 8,10,12,13,14,15 -> I_EXEC.
  - Any other opcode -> FETCH with illegal_op=1 for this cycle only.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOP=000. Opcode 35 -> MEM_RD; 43 -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1. mem_ready=1 -> MEM_WB; else stall.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
- MEM_WR: MemWrite=1, IorD=1. mem_ready=1 -> FETCH; else stall, with MemWrite held.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOP=111 -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOP=001, PCSrc=01.
  - Opcode 4 -> Branch=1; opcode 5 -> BranchNE=1.
  - Next state FETCH.
- JUMP: PCWrite=1, PCSrc=10 -> FETCH.
- I_EXEC:
  - ALUSrcA=1, ALUSrcB=10.
  - ALUOP by opcode: 8->000, 12->010, 13->011, 14->100, 10->101, 15->110.
  - ZeroExt=1 for 12/13/14. Next state I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH. ALUOP and ZeroExt stay as in I_EXEC.
- Opcode is sampled from IR every cycle. IR changes only in FETCH via IRWrite, so Opcode is stable from DECODE onward.
- Latency with mem_ready tied 1:
  - lw 5 cycles; sw, R-type and I-type 4 cycles; beq, bne and j 3 cycles.
  - Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- Unreachable state encodings (12-15) -> FETCH on the next edge, all enables 0.

Test Plan:
- rst=1 for 2 edges, mem_ready=1 -> state_dbg=0, all enables 0 during reset. First cycle after release: MemRead=1, IRWrite=1, ALUOP=000, ALUSrcB=01.
- Opcode=0 (R-type), mem_ready=1 -> states 0,1,6,7,0. ALUOP=111 in state 6. RegWrite=1 with RegDst=1 in state 7.
- Opcode=35 (lw), mem_ready low for 3 cycles in MEM_RD -> state 3 held 4 cycles with IorD=1, then MEM_WB with RegWrite=1, MemtoReg=1. Total 8 cycles.
- Opcode=5 (bne) -> states 0,1,8,0. In state 8: BranchNE=1, Branch=0, ALUOP=001, PCSrc=01.
- Opcode=13 (ori) -> I_EXEC shows ALUOP=011, ZeroExt=1. Opcode=15 (lui) -> ALUOP=110. Opcode=10 (slti) -> ALUOP=101.
- Opcode=63 -> DECODE pulses illegal_op=1 for one cycle, then state=0. Separately, rst asserted during MEM_WR with mem_ready=0 -> MemWrite=0 at once, and state=0 after the edge.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control: a Moore FSM that sequences fetch, decode, execute,
// memory and writeback, and drives the ALU-control ALUOP plus the datapath enables.
// Ports: clk, rst (sync, active high), Opcode (IR[31:26]), mem_ready (memory done).
// Outputs: ALUOP, ALUSrcA/B, ZeroExt, IorD, the Mem/IR/PC/Branch/Reg enables,
// PCSrc, RegDst, MemtoReg, illegal_op (one-cycle pulse in DECODE), state_dbg.
module mips_mc_control #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] Opcode,
  input  logic           mem_ready,
  output logic [2:0]     ALUOP,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic           ZeroExt,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           Branch,
  output logic           BranchNE,
  output logic [1:0]     PCSrc,
  output logic           RegWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           illegal_op,
  output logic [3:0]     state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_J    = OPW'(2);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(5);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(8);
  localparam logic [OPW-1:0] OP_SLTI = OPW'(10);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(12);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(13);
  localparam logic [OPW-1:0] OP_XORI = OPW'(14);
  localparam logic [OPW-1:0] OP_LUI  = OPW'(15);
  localparam logic [OPW-1:0] OP_LW   = OPW'(35);
  localparam logic [OPW-1:0] OP_SW   = OPW'(43);

  state_t     state_q, state_d;
  logic [2:0] i_aluop;
  logic       i_zext;

  // Immediate-op ALU selection, shared by I_EXEC and I_WB so the
  // ALU result stays stable through writeback.
  always_comb begin
    i_aluop = 3'b000;
    i_zext  = 1'b0;
    case (Opcode)
      OP_ANDI: begin i_aluop = 3'b010; i_zext = 1'b1; end
      OP_ORI:  begin i_aluop = 3'b011; i_zext = 1'b1; end
      OP_XORI: begin i_aluop = 3'b100; i_zext = 1'b1; end
      OP_SLTI: i_aluop = 3'b101;
      OP_LUI:  i_aluop = 3'b110;
      default: i_aluop = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ALUOP      = 3'b000;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ZeroExt    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    BranchNE   = 1'b0;
    PCSrc      = 2'b00;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_R:             state_d = S_R_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI:
                            state_d = S_I_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOP   = 3'b111;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOP    = 3'b001;
        PCSrc    = 2'b01;
        Branch   = (Opcode == OP_BEQ);
        BranchNE = (Opcode == OP_BNE);
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
        state_d = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOP   = i_aluop;
        ZeroExt = i_zext;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        ALUOP    = i_aluop;
        ZeroExt  = i_zext;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset kills every write enable immediately so an abandoned
    // instruction can't commit anything.
    if (rst) begin
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      BranchNE   = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed testbench for mips_mc_control.
// Walks each instruction class through the FSM and checks state and controls.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic [2:0] ALUOP;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ZeroExt;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic       BranchNE;
  logic [1:0] PCSrc;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int n_chk = 0;
  int n_err = 0;

  mips_mc_control #(.OPW(6)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .mem_ready(mem_ready),
    .ALUOP(ALUOP), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ZeroExt(ZeroExt), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .BranchNE(BranchNE), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_itype(input logic [5:0] op, input logic [2:0] a,
                           input logic z);
    Opcode = op;
    chk("i_fetch", 8'(state_dbg), 8'd0);
    tick();
    chk("i_dec", 8'(state_dbg), 8'd1);
    tick();
    chk("i_exec", 8'(state_dbg), 8'd10);
    chk("i_exec_aluop", 8'(ALUOP), 8'(a));
    chk("i_exec_zext", 8'(ZeroExt), 8'(z));
    chk("i_exec_srcb", 8'(ALUSrcB), 8'd2);
    tick();
    chk("i_wb", 8'(state_dbg), 8'd11);
    chk("i_wb_regwr", 8'(RegWrite), 8'd1);
    chk("i_wb_regdst", 8'(RegDst), 8'd0);
    chk("i_wb_aluop", 8'(ALUOP), 8'(a));
    chk("i_wb_zext", 8'(ZeroExt), 8'(z));
    tick();
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    Opcode = 6'd0;
    tick();
    tick();
    chk("rst_state", 8'(state_dbg), 8'd0);
    chk("rst_memrd", 8'(MemRead), 8'd0);
    chk("rst_irwr", 8'(IRWrite), 8'd0);
    chk("rst_pcwr", 8'(PCWrite), 8'd0);
    chk("rst_regwr", 8'(RegWrite), 8'd0);
    chk("rst_ill", 8'(illegal_op), 8'd0);
    rst = 1'b0;
    #1;
    chk("f_memrd", 8'(MemRead), 8'd1);
    chk("f_irwr", 8'(IRWrite), 8'd1);
    chk("f_pcwr", 8'(PCWrite), 8'd1);
    chk("f_aluop", 8'(ALUOP), 8'd0);
    chk("f_srcb", 8'(ALUSrcB), 8'd1);

    // R-type: 0,1,6,7,0
    tick();
    chk("r_dec", 8'(state_dbg), 8'd1);
    chk("r_dec_srcb", 8'(ALUSrcB), 8'd3);
    tick();
    chk("r_exec", 8'(state_dbg), 8'd6);
    chk("r_aluop", 8'(ALUOP), 8'd7);
    chk("r_srca", 8'(ALUSrcA), 8'd1);
    tick();
    chk("r_wb", 8'(state_dbg), 8'd7);
    chk("r_regwr", 8'(RegWrite), 8'd1);
    chk("r_regdst", 8'(RegDst), 8'd1);
    chk("r_m2r", 8'(MemtoReg), 8'd0);
    tick();
    chk("r_done", 8'(state_dbg), 8'd0);

    // lw with three stall cycles in MEM_RD
    Opcode = 6'd35;
    tick();
    chk("lw_dec", 8'(state_dbg), 8'd1);
    tick();
    chk("lw_addr", 8'(state_dbg), 8'd2);
    chk("lw_addr_srcb", 8'(ALUSrcB), 8'd2);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("lw_rd", 8'(state_dbg), 8'd3);
      chk("lw_iord", 8'(IorD), 8'd1);
      chk("lw_memrd", 8'(MemRead), 8'd1);
      mem_ready = (i == 3);
      tick();
    end
    chk("lw_wb", 8'(state_dbg), 8'd4);
    chk("lw_regwr", 8'(RegWrite), 8'd1);
    chk("lw_m2r", 8'(MemtoReg), 8'd1);
    chk("lw_regdst", 8'(RegDst), 8'd0);
    tick();
    chk("lw_done", 8'(state_dbg), 8'd0);

    // bne then beq
    Opcode = 6'd5;
    tick();
    tick();
    chk("bne_st", 8'(state_dbg), 8'd8);
    chk("bne_bne", 8'(BranchNE), 8'd1);
    chk("bne_beq", 8'(Branch), 8'd0);
    chk("bne_aluop", 8'(ALUOP), 8'd1);
    chk("bne_pcsrc", 8'(PCSrc), 8'd1);
    tick();
    chk("bne_done", 8'(state_dbg), 8'd0);
    Opcode = 6'd4;
    tick();
    tick();
    chk("beq_beq", 8'(Branch), 8'd1);
    chk("beq_bne", 8'(BranchNE), 8'd0);
    tick();

    // jump
    Opcode = 6'd2;
    tick();
    tick();
    chk("j_st", 8'(state_dbg), 8'd9);
    chk("j_pcwr", 8'(PCWrite), 8'd1);
    chk("j_pcsrc", 8'(PCSrc), 8'd2);
    tick();
    chk("j_done", 8'(state_dbg), 8'd0);

    run_itype(6'd13, 3'b011, 1'b1);
    run_itype(6'd15, 3'b110, 1'b0);
    run_itype(6'd10, 3'b101, 1'b0);
    run_itype(6'd12, 3'b010, 1'b1);

    // illegal opcode
    Opcode = 6'd63;
    tick();
    chk("ill_dec", 8'(state_dbg), 8'd1);
    chk("ill_pulse", 8'(illegal_op), 8'd1);
    tick();
    chk("ill_back", 8'(state_dbg), 8'd0);
    chk("ill_clear", 8'(illegal_op), 8'd0);

    // sw stalled, then reset mid-write
    Opcode = 6'd43;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    chk("sw_st", 8'(state_dbg), 8'd5);
    chk("sw_memwr", 8'(MemWrite), 8'd1);
    chk("sw_iord", 8'(IorD), 8'd1);
    tick();
    chk("sw_hold", 8'(state_dbg), 8'd5);
    chk("sw_hold_wr", 8'(MemWrite), 8'd1);
    rst = 1'b1;
    #1;
    chk("sw_rst_wr", 8'(MemWrite), 8'd0);
    tick();
    chk("sw_rst_st", 8'(state_dbg), 8'd0);
    chk("sw_rst_memrd", 8'(MemRead), 8'd0);
    rst = 1'b0;
    #1;
    // fetch stall with mem_ready low
    chk("fs_irwr", 8'(IRWrite), 8'd0);
    chk("fs_memrd", 8'(MemRead), 8'd1);
    tick();
    chk("fs_hold", 8'(state_dbg), 8'd0);
    mem_ready = 1'b1;
    tick();
    chk("fs_go", 8'(state_dbg), 8'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
